// File: rtl/sw_pkg.sv
// Shared types and helpers for the AXI-Stream switch core.
// Holds ingress/egress state encodings and width derivations.
package sw_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ING_IDLE,
    ING_FWD,
    ING_DROP
  } ing_state_e;

  typedef enum logic {
    EG_FREE,
    EG_LOCKED
  } eg_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int dest_w(input int n);
    return clog2(n);
  endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// Per-egress round-robin arbiter with frame-long grant hold.
// Grant is registered; rr_ptr remembers the last winner.
module sw_rr_arbiter
  import sw_pkg::*;
#(
  parameter int PORT_NUM = 6,
  localparam int IDX_W = clog2(PORT_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] req,
  input  logic                space_ok,
  input  logic                frame_done,
  output logic [PORT_NUM-1:0] grant,
  output logic [PORT_NUM-1:0] win,
  output logic                locked
);

  eg_state_e           state, state_nxt;
  logic [PORT_NUM-1:0] grant_nxt, pick_oh;
  logic [IDX_W-1:0]    rr_ptr, rr_nxt, pick, ix;
  logic                found;
  int                  idx;

  // search upward from the slot after the last winner
  always_comb begin
    pick_oh = '0;
    pick    = '0;
    found   = 1'b0;
    idx     = 0;
    ix      = '0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      ix = IDX_W'(idx);
      if (!found && req[ix]) begin
        found       = 1'b1;
        pick        = ix;
        pick_oh[ix] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EG_FREE;
      grant  <= '0;
      rr_ptr <= IDX_W'(PORT_NUM - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    unique case (state)
      EG_FREE:
        if (found && space_ok) begin
          state_nxt = EG_LOCKED;
          grant_nxt = pick_oh;
          rr_nxt    = pick;
        end
      EG_LOCKED:
        if (frame_done) begin
          state_nxt = EG_FREE;
          grant_nxt = '0;
        end
    endcase
  end

  always_comb begin
    locked = (state == EG_LOCKED);
    win    = (state == EG_FREE && space_ok) ? pick_oh : '0;
  end

endmodule

// File: rtl/sw_xbar_core.sv
// AXI-Stream switch: routes frames by first-beat destination index.
// Drop counters are built only when SW_DROP_CNT_EN is defined.
module sw_xbar_core
  import sw_pkg::*;
#(
  parameter int          PORT_NUM  = 6,
  parameter int          DATA_W    = 32,
  parameter int          SPACE_W   = 32,
  parameter int unsigned SPACE_MAX = 1000,
  parameter int          DEST_LSB  = 0,
  localparam int         KEEP_W    = DATA_W / 8,
  localparam int         DEST_W    = dest_w(PORT_NUM)
) (
  input  logic                           glb_clk,
  input  logic                           glb_areset,
  input  logic [PORT_NUM-1:0]            s_tvalid,
  output logic [PORT_NUM-1:0]            s_tready,
  input  logic [PORT_NUM-1:0]            s_tlast,
  input  logic [PORT_NUM*DATA_W-1:0]     s_tdata,
  input  logic [PORT_NUM*KEEP_W-1:0]     s_tkeep,
  output logic [PORT_NUM-1:0]            m_tvalid,
  input  logic [PORT_NUM-1:0]            m_tready,
  output logic [PORT_NUM-1:0]            m_tlast,
  output logic [PORT_NUM*DATA_W-1:0]     m_tdata,
  output logic [PORT_NUM*KEEP_W-1:0]     m_tkeep,
  input  logic [PORT_NUM*SPACE_W-1:0]    fifo_space_used,
  output logic [PORT_NUM*DROP_CNT_W-1:0] drop_cnt
);

  ing_state_e          ist     [PORT_NUM];
  ing_state_e          ist_nxt [PORT_NUM];
  logic [DEST_W-1:0]   dest    [PORT_NUM];
  logic [PORT_NUM-1:0] req_m   [PORT_NUM];
  logic [PORT_NUM-1:0] grant_m [PORT_NUM];
  logic [PORT_NUM-1:0] win_m   [PORT_NUM];
  logic [PORT_NUM-1:0] dest_ok, drop_hit, s_hs, won;
  logic [PORT_NUM-1:0] locked, space_ok, eg_done;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_ing
    assign dest[i]     = s_tdata[i*DATA_W+DEST_LSB +: DEST_W];
    assign dest_ok[i]  = int'(dest[i]) < PORT_NUM;
    assign drop_hit[i] = (ist[i] == ING_IDLE) && s_tvalid[i] && !dest_ok[i];
    assign s_hs[i]     = s_tvalid[i] & s_tready[i];
  end

  always_comb begin
    for (int e = 0; e < PORT_NUM; e++)
      for (int i = 0; i < PORT_NUM; i++)
        req_m[e][i] = (ist[i] == ING_IDLE) && s_tvalid[i] &&
                      dest_ok[i] && (dest[i] == DEST_W'(e));
  end

  always_comb begin
    won = '0;
    for (int e = 0; e < PORT_NUM; e++)
      won = won | win_m[e];
  end

  for (genvar e = 0; e < PORT_NUM; e++) begin : g_eg
    assign space_ok[e] =
      fifo_space_used[e*SPACE_W +: SPACE_W] < SPACE_W'(SPACE_MAX);
    assign eg_done[e] = locked[e] & m_tvalid[e] & m_tready[e] & m_tlast[e];

    sw_rr_arbiter #(
      .PORT_NUM(PORT_NUM)
    ) u_arb (
      .clk       (glb_clk),
      .rst       (glb_areset),
      .req       (req_m[e]),
      .space_ok  (space_ok[e]),
      .frame_done(eg_done[e]),
      .grant     (grant_m[e]),
      .win       (win_m[e]),
      .locked    (locked[e])
    );
  end

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      for (int i = 0; i < PORT_NUM; i++) ist[i] <= ING_IDLE;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) ist[i] <= ist_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      ist_nxt[i] = ist[i];
      unique case (ist[i])
        ING_IDLE:
          if (drop_hit[i] && !s_tlast[i]) ist_nxt[i] = ING_DROP;
          else if (won[i])                ist_nxt[i] = ING_FWD;
        ING_FWD, ING_DROP:
          if (s_hs[i] && s_tlast[i]) ist_nxt[i] = ING_IDLE;
        default: ist_nxt[i] = ING_IDLE;
      endcase
    end
  end

  // grants are one-hot and empty while FREE, so unowned egresses stay zero
  always_comb begin
    m_tvalid = '0;
    m_tlast  = '0;
    m_tdata  = '0;
    m_tkeep  = '0;
    s_tready = '0;
    for (int e = 0; e < PORT_NUM; e++)
      for (int i = 0; i < PORT_NUM; i++)
        if (grant_m[e][i]) begin
          m_tvalid[e]                 = s_tvalid[i];
          m_tlast[e]                  = s_tlast[i];
          m_tdata[e*DATA_W +: DATA_W] = s_tdata[i*DATA_W +: DATA_W];
          m_tkeep[e*KEEP_W +: KEEP_W] = s_tkeep[i*KEEP_W +: KEEP_W];
          s_tready[i]                 = m_tready[e];
        end
    for (int i = 0; i < PORT_NUM; i++)
      if (ist[i] == ING_DROP || drop_hit[i]) s_tready[i] = 1'b1;
  end

`ifdef SW_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] cnt [PORT_NUM];

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      for (int i = 0; i < PORT_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++)
        if (drop_hit[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + DROP_CNT_W'(1);
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < PORT_NUM; i++)
      drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = cnt[i];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
